// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bit positions and flag struct.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_NOR    = 4'd4,
    OP_XOR    = 4'd5,
    OP_SLL    = 4'd6,
    OP_SRL    = 4'd7,
    OP_SRA    = 4'd8,
    OP_SLT    = 4'd9,
    OP_SLTU   = 4'd10,
    OP_PASS_A = 4'd11,
    OP_SADD   = 4'd12,
    OP_SSUB   = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Field order matches the FLAG_* bit positions when packed into 4 bits.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and {Z,N,C,V} flags from a, b, op.
// Optional saturating SADD/SSUB built only when ALU_PIPE_SAT_EN is defined.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          dif;
  logic [SHW-1:0]          sh;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    ovf_add;
  logic                    ovf_sub;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign sh  = b[SHW-1:0];
  assign a_s = a;
  assign b_s = b;

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_PIPE_SAT_EN
  // On overflow the true result has the sign of a, so a's sign picks the rail.
  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v, input logic ovf,
                                           input logic neg);
    if (!ovf) return v;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    result  = '0;
    flags.c = 1'b0;
    flags.v = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result  = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = ovf_add;
      end
      OP_SUB: begin
        result  = dif[WIDTH-1:0];
        flags.c = dif[WIDTH];
        flags.v = ovf_sub;
      end
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_NOR:    result = ~(a | b);
      OP_XOR:    result = a ^ b;
      OP_SLL:    result = a << sh;
      OP_SRL:    result = a >> sh;
      OP_SRA:    result = a_s >>> sh;
      OP_SLT:    result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:   result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASS_A: result = a;
`ifdef ALU_PIPE_SAT_EN
      OP_SADD: begin
        result  = sat(sum[WIDTH-1:0], ovf_add, a[WIDTH-1]);
        flags.c = sum[WIDTH];
        flags.v = ovf_add;
      end
      OP_SSUB: begin
        result  = sat(dif[WIDTH-1:0], ovf_sub, a[WIDTH-1]);
        flags.c = dif[WIDTH];
        flags.v = ovf_sub;
      end
`endif
      default: result = '0;
    endcase
    flags.z = (result == '0);
    flags.n = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, STAGES register stages and full backpressure.
// Optional feature macro: ALU_PIPE_SAT_EN (saturating SADD/SSUB in alu_pipe_core).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // Stage index where the core result is captured, and number of payload stages.
  localparam int CAP  = (STAGES > 1) ? 1 : 0;
  localparam int NPAY = STAGES - CAP;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    flags_t           flags;
  } pay_t;

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] load_p;
  logic              accept;
  logic [WIDTH-1:0]  a_c;
  logic [WIDTH-1:0]  b_c;
  logic [3:0]        op_c;
  logic [WIDTH-1:0]  core_res;
  flags_t            core_flags;
  pay_t              pl_p [NPAY];

  // A stage may load if anything from it to the output has a free slot.
  always_comb begin
    load_p = '0;
    for (int i = 0; i < STAGES; i++) begin
      load_p[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld_p[j]) load_p[i] = 1'b1;
      end
    end
  end

  assign in_ready = !reset && load_p[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      if (load_p[0]) vld_p[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        if (load_p[i]) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Stage 0: operand register (bypassed when there is a single stage)
  if (STAGES > 1) begin : g_opreg
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [3:0]       op_p0;

    always_ff @(posedge clock) begin
      if (load_p[0]) begin
        a_p0  <= a;
        b_p0  <= b;
        op_p0 <= op;
      end
    end

    assign a_c  = a_p0;
    assign b_c  = b_p0;
    assign op_c = op_p0;
  end else begin : g_direct
    assign a_c  = a;
    assign b_c  = b;
    assign op_c = op;
  end

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a_c),
    .b      (b_c),
    .op     (op_c),
    .result (core_res),
    .flags  (core_flags)
  );

  // Stage CAP..STAGES-1: result/flag payload, later stages only carry data
  always_ff @(posedge clock) begin
    if (load_p[CAP]) pl_p[0] <= '{result: core_res, flags: core_flags};
    for (int k = 1; k < NPAY; k++) begin
      if (load_p[k+CAP]) pl_p[k] <= pl_p[k-1];
    end
  end

  // Payload is not reset; gating by valid keeps outputs at zero after reset.
  assign out_valid = vld_p[STAGES-1];
  assign result    = out_valid ? pl_p[NPAY-1].result : '0;
  assign flags     = out_valid ? pl_p[NPAY-1].flags  : 4'b0000;

endmodule
